// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised sync FIFO.
// Holds default sizes, a clog2 helper and a parameter sanity check.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Depth must be a power of two, at least 4, and the
  // threshold window must be non-empty and within depth.
  function automatic bit params_ok(
    input int depth,
    input int ae,
    input int af
  );
    return (depth >= 4) &&
           ((depth & (depth - 1)) == 0) &&
           (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port RAM: synchronous write port, registered synchronous read port.
// Ports: clk/rst_n, we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o (holds when !re_i).
module fifo_ram_2p #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset so rd_data starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, sticky errors, flush.
// Ports: clk/rst_n/clr, wr_en/wr_data, rd_en/rd_data/rd_valid, flags, count.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4,
  localparam int ADDR_W    = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_W + 1;

  if (!params_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/AE_LEVEL/AF_LEVEL");
  end

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            rvalid_q, rvalid_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            wr_ok, rd_ok;

  // Flags come only from the registered count.
  assign full         = (cnt_q == CW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CW'(AF_LEVEL));
  assign almost_empty = (cnt_q <= CW'(AE_LEVEL));

  // Flush wins over both requests in the same cycle.
  assign wr_ok = wr_en && !full && !clr;
  assign rd_ok = rd_en && !empty && !clr;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    rvalid_d = rd_ok;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (wr_en && full)  ovf_d = 1'b1;
      if (rd_en && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram_2p #(
    .DW (DATA_WIDTH),
    .AW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_ok),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  assign rd_valid  = rvalid_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO built on a two-port RAM: write-address and read-address pointers, occupancy counter, threshold flags and sticky error flags. It is the next-generation buffering block of the sync FIFO design: data width, depth and thresholds are generic, and it adds a synchronous flush. It sits between a producer and a consumer in the same clock domain.

Parameters:
DATA_WIDTH, 32, width of each stored word
DEPTH, 64, number of entries; must be a power of two and at least 4
ADDR_W, $clog2(DEPTH), RAM address width (derived; not overridden)
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush; empties FIFO and clears sticky flags
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write word
rd_en  input  1  read request
rd_data  output  DATA_WIDTH  read word, registered
rd_valid  output  1  one-cycle pulse: rd_data holds a newly read word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): wptr=rptr=0, count=0, rd_data=0, rd_valid=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=0, underflow=0. RAM contents are not reset.
- Pointers are ADDR_W+1 bits. The low ADDR_W bits address the RAM. The MSB is a wrap bit. Pointers wrap naturally at 2*DEPTH.
- Write accepted iff wr_en && !full: RAM[wptr] <= wr_data, wptr+1.
- Read accepted iff rd_en && !empty: rd_data <= RAM[rptr] on the same edge, rptr+1, rd_valid=1 in the next cycle. Latency is 1 cycle from the rd_en edge.
- When no read is accepted, rd_valid=0 and rd_data holds its last value.
- count: +1 on a write-only accept, -1 on a read-only accept, unchanged when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted, count unchanged.
  - When empty: the write is accepted and the read is rejected (underflow set). No bypass; the data is readable from the next cycle.
  - When full: the read is accepted and the write is rejected (overflow set).
- Flags are all derived from registered count/pointers only. There is no combinational path from wr_en or rd_en to any flag.
- overflow/underflow set on a rejected request and stay set until clr or reset.
- clr (synchronous, has priority over wr_en/rd_en in the same cycle): pointers and count go to 0, overflow/underflow go to 0, rd_valid=0, rd_data is held. Flags return to their reset values the next cycle.
- Reset asserted mid-operation: all state is discarded immediately. Words written before reset are never readable afterwards.
- Any RAM read-during-write to the same address cannot occur, because the empty/full gating prevents it.

Decomposition:
- Shared package sync_fifo_pkg:
  - clog2 helper function
  - default DATA_WIDTH/DEPTH constants
  - parameter-check function (DEPTH power of two, AE_LEVEL < AF_LEVEL <= DEPTH) used by an elaboration-time assertion
- One sub-module, fifo_ram_2p: parametrised two-port RAM with a synchronous write port and a synchronous registered read port on clk. It has no reset on the storage array, and it takes we/waddr/wdata and re/raddr with a registered rdata.
- Pointer, count and flag logic lives in sync_fifo_param.

Test Plan:
- Reset then idle 5 cycles -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0, rd_data=0.
- Write 1..64 (defaults) on consecutive cycles -> count reaches 64, full=1, almost_full=1 from count 60; 65th write sets overflow=1 and count stays 64.
- From full, read 64 times -> rd_valid pulses with rd_data 1..64 in order, each one cycle after its rd_en; empty=1 afterward; one extra read sets underflow=1 and rd_data stays 64.
- Fill to 10, then wr_en&rd_en together for 100 cycles with an incrementing pattern -> count stays 10, data order preserved across pointer wrap (pointer passes 127->0).
- When empty, assert wr_en&rd_en with wr_data=0xA5 -> write accepted, underflow=1, rd_valid=0; next cycle read -> rd_data=0xA5.
- Fill to 20, assert clr together with wr_en -> next cycle count=0, empty=1, overflow=underflow=0, written word discarded; then assert rst_n low mid-burst -> all outputs at reset values asynchronously.
